// File: rtl/m2vside_seq.sv
// Stage-1 side-information sequencer: holds a current and a pending macroblock header
// and presents per-block side info for blocks 0..5. Optional: M2VSIDE_SEQ_UNDERRUN_EN.
module m2vside_seq #(
  parameter int MVH_WIDTH = 16,
  parameter int MVV_WIDTH = 15,
  parameter int MBX_WIDTH = 6,
  parameter int MBY_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 mb_valid,
  output logic                 mb_ready,
  input  logic [MVH_WIDTH-1:0] mb_mv_h,
  input  logic [MVV_WIDTH-1:0] mb_mv_v,
  input  logic [MBX_WIDTH-1:0] mb_x,
  input  logic [MBY_WIDTH-1:0] mb_y,
  input  logic                 mb_intra,
  input  logic [5:0]           mb_cbp,
  input  logic                 pre_block_start,
  input  logic                 block_start,
  output logic [MVH_WIDTH-1:0] s1_mv_h,
  output logic [MVV_WIDTH-1:0] s1_mv_v,
  output logic [MBX_WIDTH-1:0] s1_mb_x,
  output logic [MBY_WIDTH-1:0] s1_mb_y,
  output logic                 s1_mb_intra,
  output logic [2:0]           s1_block,
  output logic                 s1_coded,
  output logic                 s1_enable,
  output logic                 mb_done
`ifdef M2VSIDE_SEQ_UNDERRUN_EN
  ,
  output logic                 side_underrun,
  output logic [7:0]           underrun_cnt
`endif
);

  // state   | meaning
  // S_EMPTY | no header held, s1_enable low
  // S_CUR   | current slot valid, pending slot empty
  // S_BOTH  | current and pending slots valid, header input stalled
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_CUR   = 2'd1,
    S_BOTH  = 2'd2
  } state_t;

  localparam int HDR_W = MVH_WIDTH + MVV_WIDTH + MBX_WIDTH + MBY_WIDTH + 7;

  state_t           state, state_nxt;
  logic [2:0]       blk, blk_nxt;
  logic [HDR_W-1:0] cur_hdr, pend_hdr, hdr_in;
  logic [5:0]       cur_cbp;
  logic             cur_valid, pend_valid, accept, advance;
  logic             load_cur_in, load_cur_pend, load_pend, done_nxt, cbp_bit;

  assign cur_valid  = (state != S_EMPTY);
  assign pend_valid = (state == S_BOTH);
  // Gated by reset_n so the handshake is closed while reset is held.
  assign mb_ready   = reset_n & ~pend_valid;
  assign accept     = mb_valid & mb_ready;
  assign advance    = block_start & cur_valid;
  assign hdr_in     = {mb_mv_h, mb_mv_v, mb_x, mb_y, mb_intra, mb_cbp};

  always_comb begin
    state_nxt     = state;
    blk_nxt       = blk;
    load_cur_in   = 1'b0;
    load_cur_pend = 1'b0;
    load_pend     = 1'b0;
    done_nxt      = 1'b0;
    case (state)
      S_EMPTY: begin
        if (accept) begin
          load_cur_in = 1'b1;
          blk_nxt     = 3'd0;
          state_nxt   = S_CUR;
        end
      end
      S_CUR: begin
        if (advance && blk == 3'd5) begin
          done_nxt = 1'b1;
          blk_nxt  = 3'd0;
          if (accept) load_cur_in = 1'b1;
          else        state_nxt   = S_EMPTY;
        end else begin
          if (advance) blk_nxt = blk + 3'd1;
          if (accept) begin
            load_pend = 1'b1;
            state_nxt = S_BOTH;
          end
        end
      end
      S_BOTH: begin
        if (advance && blk == 3'd5) begin
          done_nxt      = 1'b1;
          blk_nxt       = 3'd0;
          load_cur_pend = 1'b1;
          state_nxt     = S_CUR;
        end else if (advance) begin
          blk_nxt = blk + 3'd1;
        end
      end
      default: begin
        state_nxt = S_EMPTY;
        blk_nxt   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_EMPTY;
      blk      <= 3'd0;
      cur_hdr  <= '0;
      pend_hdr <= '0;
      mb_done  <= 1'b0;
    end else begin
      state   <= state_nxt;
      blk     <= blk_nxt;
      mb_done <= done_nxt;
      if (load_cur_in)        cur_hdr <= hdr_in;
      else if (load_cur_pend) cur_hdr <= pend_hdr;
      if (load_pend) pend_hdr <= hdr_in;
    end
  end

  assign {s1_mv_h, s1_mv_v, s1_mb_x, s1_mb_y, s1_mb_intra, cur_cbp} = cur_hdr;
  assign s1_block  = blk;
  assign s1_enable = cur_valid;

  // cbp is MSB-first: bit 5 belongs to block 0.
  always_comb begin
    cbp_bit = 1'b0;
    case (blk)
      3'd0:    cbp_bit = cur_cbp[5];
      3'd1:    cbp_bit = cur_cbp[4];
      3'd2:    cbp_bit = cur_cbp[3];
      3'd3:    cbp_bit = cur_cbp[2];
      3'd4:    cbp_bit = cur_cbp[1];
      3'd5:    cbp_bit = cur_cbp[0];
      default: cbp_bit = 1'b0;
    endcase
  end
  assign s1_coded = s1_mb_intra | cbp_bit;

`ifdef M2VSIDE_SEQ_UNDERRUN_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      side_underrun <= 1'b0;
      underrun_cnt  <= 8'd0;
    end else if (pre_block_start && !cur_valid && !accept) begin
      side_underrun <= 1'b1;
      if (underrun_cnt != 8'hFF) underrun_cnt <= underrun_cnt + 8'd1;
    end
  end
`else
  logic unused_pre_block_start;
  assign unused_pre_block_start = pre_block_start;
`endif

endmodule

// File: tb/tb_m2vside_seq.sv
// Scoreboard bench for m2vside_seq; expected s1_* snapshots are queued as stimulus is driven.
module tb_m2vside_seq;

  typedef struct packed {
    logic [15:0] mv_h;
    logic [14:0] mv_v;
    logic [5:0]  x;
    logic [4:0]  y;
    logic        intra;
    logic [5:0]  cbp;
  } hdr_t;

  typedef struct {
    logic       en;
    logic [2:0] blk;
    logic       coded;
    hdr_t       h;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        mb_valid, mb_ready, mb_intra, pre_block_start, block_start;
  logic [15:0] mb_mv_h, s1_mv_h;
  logic [14:0] mb_mv_v, s1_mv_v;
  logic [5:0]  mb_x, s1_mb_x, mb_cbp;
  logic [4:0]  mb_y, s1_mb_y;
  logic        s1_mb_intra, s1_coded, s1_enable, mb_done;
  logic [2:0]  s1_block;
`ifdef M2VSIDE_SEQ_UNDERRUN_EN
  logic        side_underrun;
  logic [7:0]  underrun_cnt;
`endif

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  hdr_t ha, hi, hb, hc, hd, he, hf, hg;

  always #5 clk = ~clk;

  m2vside_seq dut (
    .clk(clk), .reset_n(reset_n),
    .mb_valid(mb_valid), .mb_ready(mb_ready),
    .mb_mv_h(mb_mv_h), .mb_mv_v(mb_mv_v), .mb_x(mb_x), .mb_y(mb_y),
    .mb_intra(mb_intra), .mb_cbp(mb_cbp),
    .pre_block_start(pre_block_start), .block_start(block_start),
    .s1_mv_h(s1_mv_h), .s1_mv_v(s1_mv_v), .s1_mb_x(s1_mb_x), .s1_mb_y(s1_mb_y),
    .s1_mb_intra(s1_mb_intra), .s1_block(s1_block), .s1_coded(s1_coded),
    .s1_enable(s1_enable), .mb_done(mb_done)
`ifdef M2VSIDE_SEQ_UNDERRUN_EN
    , .side_underrun(side_underrun), .underrun_cnt(underrun_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic exp_coded(hdr_t h, int b);
    logic [5:0] c;
    c = h.cbp;
    return h.intra ? 1'b1 : c[5-b];
  endfunction

  task automatic push(input logic en, input logic [2:0] b, input hdr_t h);
    exp_t e;
    e.en    = en;
    e.blk   = b;
    e.coded = en ? exp_coded(h, int'(b)) : 1'b0;
    e.h     = h;
    sb.push_back(e);
  endtask

  task automatic check_s1();
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_depth", 64'(sb.size()), 64'd1);
      return;
    end
    e = sb.pop_front();
    chk("s1_enable", s1_enable, e.en);
    chk("s1_block", s1_block, e.blk);
    if (e.en) begin
      chk("s1_coded", s1_coded, e.coded);
      chk("s1_mb_intra", s1_mb_intra, e.h.intra);
      chk("s1_mb_x", s1_mb_x, e.h.x);
      chk("s1_mb_y", s1_mb_y, e.h.y);
      chk("s1_mv_h", s1_mv_h, e.h.mv_h);
      chk("s1_mv_v", s1_mv_v, e.h.mv_v);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_hdr(input hdr_t h);
    mb_valid = 1'b1;
    mb_mv_h  = h.mv_h;
    mb_mv_v  = h.mv_v;
    mb_x     = h.x;
    mb_y     = h.y;
    mb_intra = h.intra;
    mb_cbp   = h.cbp;
  endtask

  task automatic accept_empty(input hdr_t h);
    chk("mb_ready_idle", mb_ready, 1'b1);
    drive_hdr(h);
    cyc();
    mb_valid = 1'b0;
    push(1'b1, 3'd0, h);
    check_s1();
    chk("mb_done_first", mb_done, 1'b0);
  endtask

  task automatic bstart(input logic en, input logic [2:0] b, input hdr_t h, input logic done);
    block_start = 1'b1;
    cyc();
    block_start = 1'b0;
    push(en, b, h);
    check_s1();
    chk("mb_done", mb_done, done);
  endtask

  task automatic run_rest(input hdr_t h);
    for (int b = 1; b < 6; b++) bstart(1'b1, 3'(b), h, 1'b0);
    bstart(1'b0, 3'd0, h, 1'b1);
    cyc();
    chk("mb_done_clear", mb_done, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    ha = '{mv_h:16'h0010, mv_v:15'h7FF0, x:6'd3,  y:5'd2,  intra:1'b0, cbp:6'b101001};
    hi = '{mv_h:16'h8001, mv_v:15'h0123, x:6'd10, y:5'd7,  intra:1'b1, cbp:6'b000000};
    hb = '{mv_h:16'h1234, mv_v:15'h2AAA, x:6'd4,  y:5'd2,  intra:1'b0, cbp:6'b010110};
    hc = '{mv_h:16'hBEEF, mv_v:15'h0001, x:6'd63, y:5'd31, intra:1'b0, cbp:6'b111111};
    hd = '{mv_h:16'h0F0F, mv_v:15'h5555, x:6'd0,  y:5'd0,  intra:1'b0, cbp:6'b100001};
    he = '{mv_h:16'h0042, mv_v:15'h1111, x:6'd5,  y:5'd9,  intra:1'b0, cbp:6'b110000};
    hf = '{mv_h:16'h7777, mv_v:15'h2222, x:6'd6,  y:5'd9,  intra:1'b1, cbp:6'b000011};
    hg = '{mv_h:16'h0101, mv_v:15'h0202, x:6'd1,  y:5'd1,  intra:1'b0, cbp:6'b001100};

    reset_n = 1'b0;
    mb_valid = 1'b0; mb_mv_h = '0; mb_mv_v = '0; mb_x = '0; mb_y = '0;
    mb_intra = 1'b0; mb_cbp = '0; pre_block_start = 1'b0; block_start = 1'b0;
    #2;
    chk("rst_mb_ready", mb_ready, 1'b0);
    chk("rst_s1_enable", s1_enable, 1'b0);
    chk("rst_s1_block", s1_block, 3'd0);
    chk("rst_mb_done", mb_done, 1'b0);
    cyc();
    reset_n = 1'b1;
    #1;
    chk("release_mb_ready", mb_ready, 1'b1);

    // basic inter macroblock, then intra with cbp=0
    accept_empty(ha);
    run_rest(ha);
    accept_empty(hi);
    run_rest(hi);

    // back-to-back: B lands in pending while A is at block 1
    accept_empty(ha);
    bstart(1'b1, 3'd1, ha, 1'b0);
    drive_hdr(hb);
    cyc();
    mb_valid = 1'b0;
    push(1'b1, 3'd1, ha);
    check_s1();
    chk("b2b_ready_low", mb_ready, 1'b0);
    for (int b = 2; b < 6; b++) begin
      bstart(1'b1, 3'(b), ha, 1'b0);
      chk("b2b_ready_hold", mb_ready, 1'b0);
    end
    bstart(1'b1, 3'd0, hb, 1'b1);
    chk("b2b_ready_back", mb_ready, 1'b1);
    run_rest(hb);

    // header accepted together with the block-5 block_start
    accept_empty(hc);
    for (int b = 1; b < 6; b++) bstart(1'b1, 3'(b), hc, 1'b0);
    drive_hdr(hd);
    bstart(1'b1, 3'd0, hd, 1'b1);
    mb_valid = 1'b0;
    chk("direct_ready", mb_ready, 1'b1);
    run_rest(hd);

    // asynchronous reset with blk=3 and pending full
    accept_empty(he);
    for (int b = 1; b < 4; b++) bstart(1'b1, 3'(b), he, 1'b0);
    drive_hdr(hf);
    cyc();
    mb_valid = 1'b0;
    push(1'b1, 3'd3, he);
    check_s1();
    chk("full_ready", mb_ready, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_s1_enable", s1_enable, 1'b0);
    chk("arst_s1_block", s1_block, 3'd0);
    chk("arst_mb_ready", mb_ready, 1'b0);
    #2 reset_n = 1'b1;
    #1;
    chk("arst_release_ready", mb_ready, 1'b1);
    bstart(1'b0, 3'd0, he, 1'b0);

    // pre_block_start with nothing to present
`ifdef M2VSIDE_SEQ_UNDERRUN_EN
    chk("underrun_init", side_underrun, 1'b0);
    chk("underrun_cnt_init", underrun_cnt, 8'd0);
`endif
    for (int i = 0; i < 3; i++) begin
      pre_block_start = 1'b1;
      cyc();
      pre_block_start = 1'b0;
      cyc();
    end
    push(1'b0, 3'd0, he);
    check_s1();
`ifdef M2VSIDE_SEQ_UNDERRUN_EN
    chk("underrun_flag", side_underrun, 1'b1);
    chk("underrun_cnt", underrun_cnt, 8'd3);
    pre_block_start = 1'b1;
    drive_hdr(hg);
    cyc();
    pre_block_start = 1'b0;
    mb_valid = 1'b0;
    chk("underrun_cnt_accept", underrun_cnt, 8'd3);
    push(1'b1, 3'd0, hg);
    check_s1();
`endif

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
